// File: rtl/ram2_arbiter.sv
// Shares the single-port RAM2 between instruction fetch and MEM-stage loads/stores, stalling the pipeline during data access.
// Optional RAM2_WR_PROTECT_EN: stores below PROT_LIMIT are dropped and flagged on wr_fault_o.
module ram2_arbiter #(
   parameter int          RAM_AW     = 14,
   parameter int          WE_CYCLES  = 1,
   parameter logic [15:0] NOP_INST   = 16'h0800,
   parameter logic [15:0] PROT_LIMIT = 16'h4000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       if_pc_i,
   output logic [15:0]       if_inst_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [15:0]       mem_addr_i,
   input  logic [15:0]       mem_data_i,
   output logic [15:0]       mem_data_o,
   output logic              stall_req_o,
   output logic              wr_fault_o,
   output logic [RAM_AW-1:0] ram_addr_o,
   output logic [15:0]       ram_data_o,
   input  logic [15:0]       ram_data_i,
   output logic              ram_data_oe_o,
   output logic              ram_en_o,
   output logic              ram_oe_o,
   output logic              ram_we_o
);

   typedef enum logic [2:0] {S_FETCH, S_DRD, S_WSU, S_WPL, S_WHD, S_DONE} state_t;

   localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

   state_t             state_q, state_d;
   logic [RAM_AW-1:0]  req_addr_q, req_addr_d;
   logic [15:0]        req_data_q, req_data_d;
   logic               req_we_q, req_we_d;
   logic [15:0]        if_inst_q, if_inst_d;
   logic [15:0]        mem_data_q, mem_data_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               fault_d;
   logic               unused_bits;

   assign unused_bits = ^{if_pc_i[15:RAM_AW], mem_addr_i[15:RAM_AW], fault_d};

   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      req_data_d    = req_data_q;
      req_we_d      = req_we_q;
      if_inst_d     = if_inst_q;
      mem_data_d    = mem_data_q;
      cnt_d         = cnt_q;
      fault_d       = 1'b0;
      ram_addr_o    = req_addr_q;
      ram_en_o      = 1'b0;
      ram_oe_o      = 1'b1;
      ram_we_o      = 1'b1;
      ram_data_oe_o = 1'b0;
      stall_req_o   = 1'b1;

      case (state_q)
         S_FETCH: begin
            ram_addr_o  = if_pc_i[RAM_AW-1:0];
            ram_oe_o    = 1'b0;
            stall_req_o = mem_ce_i;
            if (mem_ce_i) begin
               req_addr_d = mem_addr_i[RAM_AW-1:0];
               req_data_d = mem_data_i;
               req_we_d   = mem_we_i;
               if (!mem_we_i) begin
                  state_d = S_DRD;
`ifdef RAM2_WR_PROTECT_EN
               end else if (mem_addr_i < PROT_LIMIT) begin
                  state_d = S_DONE;
                  fault_d = 1'b1;
`endif
               end else begin
                  state_d = S_WSU;
               end
            end else begin
               if_inst_d = ram_data_i;
            end
         end
         S_DRD: begin
            ram_oe_o   = 1'b0;
            mem_data_d = ram_data_i;
            state_d    = S_DONE;
         end
         S_WSU: begin
            ram_data_oe_o = req_we_q;
            cnt_d         = CW'(WE_CYCLES - 1);
            state_d       = S_WPL;
         end
         S_WPL: begin
            ram_data_oe_o = req_we_q;
            ram_we_o      = 1'b0;
            if (cnt_q == '0) begin
               state_d = S_WHD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WHD: begin
            ram_data_oe_o = req_we_q;
            state_d       = S_DONE;
         end
         S_DONE: begin
            // Pipeline advances on this edge, so the current mem_ce_i is the request just served.
            ram_addr_o  = if_pc_i[RAM_AW-1:0];
            ram_oe_o    = 1'b0;
            stall_req_o = 1'b0;
            if_inst_d   = ram_data_i;
            state_d     = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Strobes go idle the moment reset asserts, even mid write pulse.
      if (rst) begin
         ram_en_o      = 1'b1;
         ram_oe_o      = 1'b1;
         ram_we_o      = 1'b1;
         ram_data_oe_o = 1'b0;
         stall_req_o   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         req_addr_q <= '0;
         req_data_q <= '0;
         req_we_q   <= 1'b0;
         if_inst_q  <= NOP_INST;
         mem_data_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         req_data_q <= req_data_d;
         req_we_q   <= req_we_d;
         if_inst_q  <= if_inst_d;
         mem_data_q <= mem_data_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef RAM2_WR_PROTECT_EN
   logic fault_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign wr_fault_o = fault_q;
`else
   assign wr_fault_o = 1'b0;
`endif

   assign if_inst_o  = if_inst_q;
   assign mem_data_o = mem_data_q;
   assign ram_data_o = req_data_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with a behavioural RAM2 model (WE_CYCLES = 2).
module tb_ram2_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] if_pc_i;
   logic [15:0] if_inst_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [15:0] mem_addr_i;
   logic [15:0] mem_data_i;
   logic [15:0] mem_data_o;
   logic        stall_req_o;
   logic        wr_fault_o;
   logic [13:0] ram_addr_o;
   logic [15:0] ram_data_o;
   logic [15:0] ram_data_i;
   logic        ram_data_oe_o;
   logic        ram_en_o;
   logic        ram_oe_o;
   logic        ram_we_o;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:16383];

   int          we_low, we_falls, oe_cyc, bus_bad, fault_cyc;
   logic        prev_we;
   logic [13:0] last_rd_addr;
   logic [15:0] exp_a, exp_d;

   ram2_arbiter #(.RAM_AW(14), .WE_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .if_pc_i(if_pc_i), .if_inst_o(if_inst_o),
      .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
      .stall_req_o(stall_req_o), .wr_fault_o(wr_fault_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
      .ram_data_oe_o(ram_data_oe_o), .ram_en_o(ram_en_o),
      .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o)
   );

   always #5 clk = ~clk;

   assign ram_data_i = (!ram_en_o && !ram_oe_o) ? mem[ram_addr_o] : 16'hDEAD;

   always @(posedge clk) begin
      if (!ram_en_o && !ram_we_o) mem[ram_addr_o] = ram_data_o;
   end

   // Bus observer, sampled mid low phase after the bench has driven its inputs.
   always begin
      @(negedge clk);
      #2;
      if (!ram_we_o) we_low++;
      if (!ram_we_o && prev_we) we_falls++;
      prev_we = ram_we_o;
      if (ram_data_oe_o) begin
         oe_cyc++;
         if (ram_addr_o != exp_a[13:0] || ram_data_o != exp_d || !ram_oe_o) bus_bad++;
      end
      if (wr_fault_o) fault_cyc++;
      if (stall_req_o && !ram_oe_o) last_rd_addr = ram_addr_o;
   end

   task automatic clear_mon(input logic [15:0] a, input logic [15:0] d);
      we_low = 0; we_falls = 0; oe_cyc = 0; bus_bad = 0; fault_cyc = 0;
      prev_we = 1'b1; exp_a = a; exp_d = d; last_rd_addr = '0;
   endtask

   task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                            output int stalls);
      @(negedge clk);
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_data_i = d;
      stalls = 0;
      #1;
      while (stall_req_o === 1'b1 && stalls < 20) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      mem_ce_i = 1'b0;
      #2;
   endtask

   task automatic test_reset;
      rst = 1'b1; if_pc_i = 16'h0000; mem_ce_i = 1'b0; mem_we_i = 1'b0;
      mem_addr_i = '0; mem_data_i = '0;
      mem[0] = 16'h6901; mem[1] = 16'h1111;
      #22;
      checks++;
      if (if_inst_o !== 16'h0800) begin
         errors++; $display("FAIL reset_inst got %h exp 0800", if_inst_o);
      end
      checks++;
      if (mem_data_o !== 16'h0000) begin
         errors++; $display("FAIL reset_mem_data got %h exp 0000", mem_data_o);
      end
      checks++;
      if ({ram_en_o, ram_oe_o, ram_we_o, ram_data_oe_o, stall_req_o, wr_fault_o} !== 6'b111000) begin
         errors++;
         $display("FAIL reset_strobes got %b exp 111000",
                  {ram_en_o, ram_oe_o, ram_we_o, ram_data_oe_o, stall_req_o, wr_fault_o});
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (if_inst_o !== 16'h6901) begin
         errors++; $display("FAIL first_fetch got %h exp 6901", if_inst_o);
      end
      checks++;
      if (stall_req_o !== 1'b0) begin
         errors++; $display("FAIL idle_stall got %b exp 0", stall_req_o);
      end
   endtask

   task automatic test_load;
      int st;
      mem[16'h0105] = 16'hBEEF;
      if_pc_i = 16'h0001;
      clear_mon(16'h0105, 16'h0000);
      do_access(1'b0, 16'h0105, 16'h0000, st);
      checks++;
      if (st !== 2) begin errors++; $display("FAIL load_stall got %0d exp 2", st); end
      checks++;
      if (mem_data_o !== 16'hBEEF) begin
         errors++; $display("FAIL load_data got %h exp BEEF", mem_data_o);
      end
      checks++;
      if (we_low !== 0) begin errors++; $display("FAIL load_we got %0d exp 0", we_low); end
      checks++;
      if (last_rd_addr !== 14'h0105) begin
         errors++; $display("FAIL load_addr got %h exp 0105", last_rd_addr);
      end
      checks++;
      if (if_inst_o !== 16'h6901) begin
         errors++; $display("FAIL inst_hold got %h exp 6901", if_inst_o);
      end
      @(posedge clk); #1;
      checks++;
      if (if_inst_o !== 16'h1111) begin
         errors++; $display("FAIL done_fetch got %h exp 1111", if_inst_o);
      end
   endtask

   task automatic test_store;
      int st;
      clear_mon(16'h4010, 16'h1234);
      do_access(1'b1, 16'h4010, 16'h1234, st);
      checks++;
      if (st !== 5) begin errors++; $display("FAIL store_stall got %0d exp 5", st); end
      checks++;
      if (we_low !== 2 || we_falls !== 1) begin
         errors++; $display("FAIL store_we got low=%0d falls=%0d exp low=2 falls=1", we_low, we_falls);
      end
      checks++;
      if (oe_cyc !== 4 || bus_bad !== 0) begin
         errors++; $display("FAIL store_bus got oe=%0d bad=%0d exp oe=4 bad=0", oe_cyc, bus_bad);
      end
      checks++;
      if (mem[16'h0010] !== 16'h1234) begin
         errors++; $display("FAIL store_mem got %h exp 1234", mem[16'h0010]);
      end
      do_access(1'b0, 16'h4010, 16'h0000, st);
      checks++;
      if (mem_data_o !== 16'h1234) begin
         errors++; $display("FAIL store_readback got %h exp 1234", mem_data_o);
      end
   endtask

   task automatic test_wrap;
      int st;
      mem[16'h0003] = 16'hA5A5;
      clear_mon(16'h0000, 16'h0000);
      do_access(1'b0, 16'hC003, 16'h0000, st);
      checks++;
      if (last_rd_addr !== 14'h0003) begin
         errors++; $display("FAIL wrap_addr got %h exp 0003", last_rd_addr);
      end
      checks++;
      if (mem_data_o !== 16'hA5A5) begin
         errors++; $display("FAIL wrap_data got %h exp A5A5", mem_data_o);
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] pat;
      mem[16'h0020] = 16'h2020; mem[16'h0021] = 16'h2121;
      pat = '0;
      @(negedge clk);
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'h0020;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         pat[i] = stall_req_o;
         if (i == 2) begin
            checks++;
            if (mem_data_o !== 16'h2020) begin
               errors++; $display("FAIL b2b_first got %h exp 2020", mem_data_o);
            end
            mem_addr_i = 16'h0021;
         end
      end
      mem_ce_i = 1'b0;
      checks++;
      if (pat !== 6'b011011) begin
         errors++; $display("FAIL b2b_stall got %b exp 011011", pat);
      end
      checks++;
      if (mem_data_o !== 16'h2121) begin
         errors++; $display("FAIL b2b_second got %h exp 2121", mem_data_o);
      end
   endtask

   task automatic test_reset_mid_write;
      @(negedge clk);
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h4020; mem_data_i = 16'h5555;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (ram_we_o !== 1'b0) begin errors++; $display("FAIL wpl_we got %b exp 0", ram_we_o); end
      rst = 1'b1; mem_ce_i = 1'b0;
      #1;
      checks++;
      if ({ram_we_o, ram_data_oe_o} !== 2'b10) begin
         errors++; $display("FAIL abort_strobes got %b exp 10", {ram_we_o, ram_data_oe_o});
      end
      checks++;
      if (if_inst_o !== 16'h0800) begin
         errors++; $display("FAIL abort_inst got %h exp 0800", if_inst_o);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({stall_req_o, ram_oe_o, ram_addr_o} !== {2'b00, 14'h0001}) begin
         errors++;
         $display("FAIL post_abort got stall=%b oe=%b addr=%h exp 0 0 0001", stall_req_o, ram_oe_o, ram_addr_o);
      end
      checks++;
      if (if_inst_o !== 16'h1111 || mem[16'h0020] !== 16'h2020) begin
         errors++;
         $display("FAIL post_abort_data got inst=%h mem=%h exp 1111 2020", if_inst_o, mem[16'h0020]);
      end
   endtask

   task automatic test_protect;
      int st;
      clear_mon(16'h0010, 16'h9999);
      do_access(1'b1, 16'h0010, 16'h9999, st);
`ifdef RAM2_WR_PROTECT_EN
      checks++;
      if (st !== 1 || we_low !== 0) begin
         errors++; $display("FAIL prot_drop got stall=%0d we_low=%0d exp 1 0", st, we_low);
      end
      checks++;
      if (fault_cyc !== 1) begin errors++; $display("FAIL prot_fault got %0d exp 1", fault_cyc); end
      checks++;
      if (mem[16'h0010] !== 16'h1234) begin
         errors++; $display("FAIL prot_mem got %h exp 1234", mem[16'h0010]);
      end
`else
      checks++;
      if (st !== 5 || we_low !== 2) begin
         errors++; $display("FAIL low_store got stall=%0d we_low=%0d exp 5 2", st, we_low);
      end
      checks++;
      if (fault_cyc !== 0) begin errors++; $display("FAIL low_fault got %0d exp 0", fault_cyc); end
      checks++;
      if (mem[16'h0010] !== 16'h9999) begin
         errors++; $display("FAIL low_mem got %h exp 9999", mem[16'h0010]);
      end
`endif
      clear_mon(16'h4000, 16'h7777);
      do_access(1'b1, 16'h4000, 16'h7777, st);
      checks++;
      if (st !== 5 || fault_cyc !== 0 || mem[16'h0000] !== 16'h7777) begin
         errors++;
         $display("FAIL limit_store got stall=%0d fault=%0d mem=%h exp 5 0 7777", st, fault_cyc, mem[16'h0000]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
      clear_mon(16'h0000, 16'h0000);
      test_reset;
      test_load;
      test_store;
      test_wrap;
      test_back_to_back;
      test_reset_mid_write;
      test_protect;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end

endmodule

// File: doc/ram2_arbiter.md
Name: ram2_arbiter

Overview:
- Sits between the CPU pipeline (IF and MEM stages) and the RAM2 word memory, which holds both instructions and data.
- RAM2 has one port. The block fetches an instruction every cycle by default.
- When MEM issues a load or store, the block takes RAM2 away from fetch, sequences the SRAM control strobes, and stalls the pipeline until the access completes.

Parameters:
- RAM_AW, 14, RAM2 word-address width; ram_addr_o = selected_addr[RAM_AW-1:0].
- WE_CYCLES, 1, length of the write-enable low pulse in cycles (>=1).
- NOP_INST, 16'h0800, instruction value after reset.
- PROT_LIMIT, 16'h4000, first writable address (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc_i  in  16  fetch address.
- if_inst_o  out  16  fetched instruction (registered).
- mem_ce_i  in  1  MEM-stage access request.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  16  data address.
- mem_data_i  in  16  store data.
- mem_data_o  out  16  load data (registered).
- stall_req_o  out  1  pipeline stall request.
- wr_fault_o  out  1  one-cycle pulse on a dropped protected write.
- ram_addr_o  out  RAM_AW  RAM2 address.
- ram_data_o  out  16  RAM2 write data.
- ram_data_i  in  16  RAM2 read data.
- ram_data_oe_o  out  1  drive enable for the write bus.
- ram_en_o  out  1  chip enable, active-low.
- ram_oe_o  out  1  output enable, active-low.
- ram_we_o  out  1  write enable, active-low.

Behaviour:
- Reset (asynchronous, while rst=1):
  - State = S_FETCH.
  - if_inst_o = NOP_INST, mem_data_o = 0.
  - ram_en_o = ram_oe_o = ram_we_o = 1, ram_data_oe_o = 0, stall_req_o = 0, wr_fault_o = 0.
  - Reset mid-access aborts immediately; ram_we_o returns high asynchronously.
- States: S_FETCH, S_DRD, S_WSU, S_WPL, S_WHD, S_DONE.
- Strobes are decoded from the state; latched request registers are req_addr, req_data and req_we.
- S_FETCH:
  - Drives ram_addr_o = if_pc_i, en = 0, oe = 0, we = 1.
  - Each edge: if_inst_o <= ram_data_i.
  - If mem_ce_i = 1: stall_req_o = 1 (combinational), if_inst_o holds, the request is latched, and the next state is S_DRD (load) or S_WSU (store).
- S_DRD:
  - Drives addr = req_addr, en = 0, oe = 0, stall = 1.
  - At the edge: mem_data_o <= ram_data_i, then go to S_DONE.
- S_WSU:
  - Drives addr = req_addr, ram_data_o = req_data, ram_data_oe_o = 1, en = 0, oe = 1, we = 1, stall = 1.
  - Goes to S_WPL.
- S_WPL:
  - As S_WSU but with we = 0.
  - Stays WE_CYCLES cycles (down-counter), then goes to S_WHD.
- S_WHD:
  - As S_WSU (we = 1, data still driven).
  - Goes to S_DONE.
- S_DONE:
  - stall = 0; fetches exactly as S_FETCH (if_inst_o captured); mem_data_o held.
  - Always returns to S_FETCH; mem_ce_i is ignored in this cycle.
  - The pipeline advances at this edge, so the same request is never re-serviced.
- Stall lengths:
  - Load: 2 cycles (request cycle + S_DRD).
  - Store: 3 + WE_CYCLES cycles.
  - Back-to-back requests: S_DONE → S_FETCH → new access (one fetch cycle in between, stalled).
- Address bits above RAM_AW are ignored (wrap).
- mem_data_o changes only on S_DRD exit.
- wr_fault_o = 0 unless the feature is enabled.
- ram_data_oe_o = 1 only in S_WSU, S_WPL and S_WHD.

Optional Feature:
- Macro: RAM2_WR_PROTECT_EN.
- Defined: a store with mem_addr_i < PROT_LIMIT goes S_FETCH → S_DONE. No strobes are issued, ram_we_o never falls, stall lasts 1 cycle, and wr_fault_o pulses for 1 cycle in S_DONE.
- Undefined: all stores execute normally and wr_fault_o is tied 0.

Test Plan:
1. Reset, pc = 0 with ram[0] = 16'h6901, no mem_ce_i → if_inst_o = 16'h0800 during reset and 16'h6901 one edge after release; stall_req_o stays 0.
2. Load: ram[16'h0105] = 16'hBEEF, mem_ce_i = 1, mem_we_i = 0, addr = 16'h0105 → stall high 2 cycles, mem_data_o = 16'hBEEF at S_DONE, ram_we_o never low.
3. Store: addr = 16'h4010, data = 16'h1234, WE_CYCLES = 2 → stall 5 cycles, ram_we_o low exactly 2 cycles with addr/data stable one cycle before and after, memory reads back 16'h1234.
4. Address wrap: load from addr 16'hC003 → ram_addr_o = 14'h0003.
5. Reset asserted during S_WPL → ram_we_o high and ram_data_oe_o = 0 immediately (no clock); state S_FETCH after release.
6. With RAM2_WR_PROTECT_EN: store to 16'h0010 → 1-cycle stall, wr_fault_o = 1 for 1 cycle, memory unchanged. Store to 16'h4000 → normal write.
